// File: rtl/skinny_inv_sbox_iter.sv
`default_nettype none
// ============================================================================
// Module      : skinny_inv_sbox_iter
// Description : 3-share masked inverse SKINNY-64 S-box, iterative NOR-step
//               datapath with one registered DOM-indep AND gadget.
//               Optional output remasking: SKINNY_INV_SBOX_REMASK_EN
// Revision    : 1.0 - initial release
// ============================================================================
module skinny_inv_sbox_iter #(
    parameter int NUM_STEPS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic [3:0] in3,
    input  logic [2:0] r,
    input  logic [1:0] r_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out1,
    output logic [3:0] out2,
    output logic [3:0] out3
);

    localparam int C_CNT_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(NUM_STEPS - 1);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_MUL  = 2'd1;
    localparam logic [1:0] C_UPD  = 2'd2;
    localparam logic [1:0] C_DONE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [C_CNT_W-1:0] r_cnt;
    logic [3:0]         r_sh1, r_sh2, r_sh3;
    logic [2:0]         r_inner;
    logic [5:0]         r_cross;   // {c32, c31, c23, c21, c13, c12}

    logic       w_a1, w_a2, w_a3, w_b1, w_b2, w_b3;
    logic       w_z1, w_z2, w_z3;
    logic [3:0] w_upd1, w_upd2, w_upd3;
    logic [3:0] w_rot1, w_rot2, w_rot3;
    logic [3:0] w_rm1, w_rm2, w_rm3;
    logic       w_last;

    // NOR operands: complement lives in share 1 only
    assign w_a1 = ~r_sh1[3];
    assign w_a2 =  r_sh2[3];
    assign w_a3 =  r_sh3[3];
    assign w_b1 = ~r_sh1[2];
    assign w_b2 =  r_sh2[2];
    assign w_b3 =  r_sh3[2];

    assign w_z1 = r_inner[0] ^ r_cross[0] ^ r_cross[1];
    assign w_z2 = r_inner[1] ^ r_cross[2] ^ r_cross[3];
    assign w_z3 = r_inner[2] ^ r_cross[4] ^ r_cross[5];

    assign w_upd1 = {r_sh1[3:1], r_sh1[0] ^ w_z1};
    assign w_upd2 = {r_sh2[3:1], r_sh2[0] ^ w_z2};
    assign w_upd3 = {r_sh3[3:1], r_sh3[0] ^ w_z3};

    assign w_rot1 = {w_upd1[0], w_upd1[3:1]};
    assign w_rot2 = {w_upd2[0], w_upd2[3:1]};
    assign w_rot3 = {w_upd3[0], w_upd3[3:1]};

    assign w_last = (r_cnt == C_LAST);

`ifdef SKINNY_INV_SBOX_REMASK_EN
    // Remask masks XOR to zero, so the unmasked result is preserved
    assign w_rm1 = {4{r_out[0]}};
    assign w_rm2 = {4{r_out[1]}};
    assign w_rm3 = {4{r_out[0] ^ r_out[1]}};
`else
    logic w_unused_r_out;
    assign w_unused_r_out = ^r_out;
    assign w_rm1 = 4'b0;
    assign w_rm2 = 4'b0;
    assign w_rm3 = 4'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            C_IDLE:  if (in_valid) w_next_state = C_MUL;
            C_MUL:   w_next_state = C_UPD;
            C_UPD:   w_next_state = w_last ? C_DONE : C_MUL;
            C_DONE:  if (out_ready) w_next_state = C_IDLE;
            default: w_next_state = C_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == C_IDLE);
        out_valid = (r_state == C_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_sh1   <= 4'b0;
            r_sh2   <= 4'b0;
            r_sh3   <= 4'b0;
            r_inner <= 3'b0;
            r_cross <= 6'b0;
        end else begin
            case (r_state)
                C_IDLE: begin
                    if (in_valid) begin
                        r_sh1 <= in1;
                        r_sh2 <= in2;
                        r_sh3 <= in3;
                        r_cnt <= '0;
                    end
                end
                C_MUL: begin
                    r_inner[0] <= w_a1 & w_b1;
                    r_inner[1] <= w_a2 & w_b2;
                    r_inner[2] <= w_a3 & w_b3;
                    r_cross[0] <= (w_a1 & w_b2) ^ r[0];
                    r_cross[1] <= (w_a1 & w_b3) ^ r[1];
                    r_cross[2] <= (w_a2 & w_b1) ^ r[0];
                    r_cross[3] <= (w_a2 & w_b3) ^ r[2];
                    r_cross[4] <= (w_a3 & w_b1) ^ r[1];
                    r_cross[5] <= (w_a3 & w_b2) ^ r[2];
                end
                C_UPD: begin
                    if (w_last) begin
                        r_sh1 <= w_upd1 ^ w_rm1;
                        r_sh2 <= w_upd2 ^ w_rm2;
                        r_sh3 <= w_upd3 ^ w_rm3;
                    end else begin
                        r_sh1 <= w_rot1;
                        r_sh2 <= w_rot2;
                        r_sh3 <= w_rot3;
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out1 = r_sh1;
    assign out2 = r_sh2;
    assign out3 = r_sh3;

endmodule
`default_nettype wire

// File: tb/tb_skinny_inv_sbox_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_skinny_inv_sbox_iter
// Description : Directed self-checking bench for skinny_inv_sbox_iter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skinny_inv_sbox_iter;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in1, in2, in3;
    logic [2:0] r;
    logic [1:0] r_out;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out1, out2, out3;

    int n_checks = 0;
    int n_errors = 0;

    skinny_inv_sbox_iter #(.NUM_STEPS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .r         (r),
        .r_out     (r_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out1      (out1),
        .out2      (out2),
        .out3      (out3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] sinv(input logic [3:0] x);
        case (x)
            4'h0: sinv = 4'h3;  4'h1: sinv = 4'h4;  4'h2: sinv = 4'h6;  4'h3: sinv = 4'h8;
            4'h4: sinv = 4'hc;  4'h5: sinv = 4'ha;  4'h6: sinv = 4'h1;  4'h7: sinv = 4'he;
            4'h8: sinv = 4'h9;  4'h9: sinv = 4'h2;  4'ha: sinv = 4'h5;  4'hb: sinv = 4'h7;
            4'hc: sinv = 4'h0;  4'hd: sinv = 4'hb;  4'he: sinv = 4'hd;  default: sinv = 4'hf;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic start_op(input logic [3:0] nib, input logic [3:0] s2, input logic [3:0] s3);
        check("in_ready_before_op", {31'b0, in_ready}, 32'd1);
        in1      = nib ^ s2 ^ s3;
        in2      = s2;
        in3      = s3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input bit zero_r, output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            r = zero_r ? 3'b0 : 3'($urandom);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
    endtask

    task automatic finish_op();
        @(posedge clk);
        @(negedge clk);
        check("valid_drop", {31'b0, out_valid}, 32'd0);
        check("ready_back", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        int         n;
        logic [3:0] o1, o2, o3;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in1       = 4'h0;
        in2       = 4'h0;
        in3       = 4'h0;
        r         = 3'b0;
        r_out     = 2'b00;
        out_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out1", {28'b0, out1}, 32'h0);
        check("rst_out2", {28'b0, out2}, 32'h0);
        check("rst_out3", {28'b0, out3}, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        rst = 1'b0;

        // All 16 nibbles, random sharing and randomness
        for (int v = 0; v < 16; v++) begin
            start_op(4'(v), 4'($urandom), 4'($urandom));
            wait_done(1'b0, n);
            check("latency", n, 32'd8);
            check("sbox_xor", {28'b0, out1 ^ out2 ^ out3}, {28'b0, sinv(4'(v))});
            finish_op();
        end

        // Trivial sharing, zero randomness
        start_op(4'hc, 4'h0, 4'h0);
        wait_done(1'b1, n);
        check("trivial_latency", n, 32'd8);
        check("trivial_xor", {28'b0, out1 ^ out2 ^ out3}, 32'h0);
        finish_op();

        // Backpressure in DONE
        out_ready = 1'b0;
        start_op(4'h6, 4'($urandom), 4'($urandom));
        wait_done(1'b0, n);
        check("bp_latency", n, 32'd8);
        o1 = out1;
        o2 = out2;
        o3 = out3;
        check("bp_xor", {28'b0, o1 ^ o2 ^ o3}, 32'h1);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in1      = 4'($urandom);
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_ready", {31'b0, in_ready}, 32'd0);
            check("bp_hold", {20'b0, out1, out2, out3}, {20'b0, o1, o2, o3});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        finish_op();

        // Reset during the second UPD
        start_op(4'h3, 4'($urandom), 4'($urandom));
        repeat (3) begin
            r = 3'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_ready", {31'b0, in_ready}, 32'd1);
        check("abort_outs", {20'b0, out1, out2, out3}, 32'h0);
        start_op(4'h9, 4'($urandom), 4'($urandom));
        wait_done(1'b0, n);
        check("after_abort_latency", n, 32'd8);
        check("after_abort_xor", {28'b0, out1 ^ out2 ^ out3}, 32'h2);
        finish_op();

`ifdef SKINNY_INV_SBOX_REMASK_EN
        r_out = 2'b11;
        start_op(4'h5, 4'h0, 4'h0);
        wait_done(1'b0, n);
        check("remask_latency", n, 32'd8);
        check("remask_xor", {28'b0, out1 ^ out2 ^ out3}, 32'ha);
        finish_op();
        r_out = 2'b00;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/skinny_inv_sbox_iter.md
Name: skinny_inv_sbox_iter

Overview:
- Second-order (3-share) masked inverse SKINNY-64 4-bit S-box for the decryption datapath.
- Counterpart of the forward masked S-box on the encryption side.
- Iterative, low-area: four inverse NOR-steps, each using one DOM-indep masked AND gadget with a register stage between the cross terms and compression.
- Takes one nibble per operation via a valid/ready handshake; returns three output shares.

Parameters:
- NUM_STEPS, 4, number of inverse NOR-steps. Fixed at 4 for SKINNY-64; other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input shares valid
- in_ready  output  1  high only in IDLE
- in1  input  4  share 1 of ciphertext nibble; bit0 = x0
- in2  input  4  share 2
- in3  input  4  share 3
- r  input  3  fresh randomness; sampled at every MUL edge
- r_out  input  2  output remask bits; ignored unless macro defined
- out_valid  output  1  output shares valid
- out_ready  input  1  consumer accepts outputs
- out1  output  4  output share 1
- out2  output  4  output share 2
- out3  output  4  output share 3

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, step counter=0, DOM term registers=0, share registers=0.
  - out1..3=0, out_valid=0, in_ready=1 after the edge.
  - Reset mid-operation aborts it; no partial output is ever flagged valid.
- Functional requirement: out1^out2^out3 = S4inv(in1^in2^in3).
  - S4inv table, index 0..f: 3,4,6,8,c,a,1,e,9,2,5,7,0,b,d,f.
- Step operation: x0 ^= NOT(x3 OR x2), implemented as (~x3)&(~x2).
  - Complement is applied to share 1 only.
- Sequence per nibble: [step, rotR] x3, then a final step.
  - rotR: (x3,x2,x1,x0) -> (x0,x3,x2,x1).
- Masked AND (operands a=~x3, b=~x2, shares i=1..3):
  - Randomness mapping: r12=r[0], r13=r[1], r23=r[2].
  - MUL edge registers inner terms a_i&b_i.
  - MUL edge also registers cross terms a_i&b_j ^ r_ij (r_ji = r_ij).
  - UPD computes z_i = inner_i ^ cross_ij ^ cross_ik from registers only.
- FSM states: IDLE, MUL, UPD, DONE.
  - IDLE: on in_valid&in_ready, load shares, counter=0, go to MUL. in_valid outside IDLE is ignored.
  - MUL: register the 9 DOM terms, go to UPD.
  - UPD: x0_i ^= z_i. If counter<3: apply rotR to all shares, counter++, go to MUL. Else go to DONE.
  - DONE: out_valid=1; out1..3 driven from share registers and held stable. If out_ready, go to IDLE (out_valid drops next cycle).
- Latency: out_valid rises 8 cycles after the accepting edge.
  - One idle bubble after each output; sustained throughput is 1 nibble per 10 cycles with out_ready tied high.
- Share separation: share registers and DOM term registers update only on their own state edges. No combinational path mixes share domains except through registered cross terms.
- r must be fresh in each of the 4 MUL cycles, 12 bits per nibble. Correctness holds for any r value; security does not.

Optional Feature:
- Macro: SKINNY_INV_SBOX_REMASK_EN
- Defined: on the final UPD edge, additionally out1 ^= r_out[0], out2 ^= r_out[1], out3 ^= r_out[0]^r_out[1]. Unmasked value is unchanged; latency is unchanged.
- Undefined: r_out is ignored; outputs equal the final share registers.

Test Plan:
- Reset: rst high 2 cycles -> out1..3=0, out_valid=0, in_ready=1.
- Exhaustive: all 16 nibbles with random shares and random r, out_ready=1 -> XOR of outputs matches S4inv. Examples: c->0, 0->3, 6->1; out_valid exactly 8 cycles after accept.
- Zero randomness / trivial sharing: in1=c, in2=0, in3=0, r=0 -> out1^out2^out3=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> outputs and out_valid stable; in_ready=0; in_valid pulses ignored. Release -> IDLE next cycle.
- Reset mid-operation: assert rst during the 2nd UPD -> next cycle IDLE, outputs 0, out_valid=0. A following nibble 9 -> 2 correct.
- With SKINNY_INV_SBOX_REMASK_EN: in=5 (shares 5,0,0), r_out=2'b11 -> out1^out2^out3=a. Individual shares differ from the macro-off run.
